// File: rtl/hold_arbiter_pkg.sv
// Shared types and helpers for the CPU-HOLD bus-ownership arbiter.
package hold_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        GRANT,
        RELEASE,
        CPU_GAP
    } arb_state_e;

    // Width of a requester index; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hold_arbiter_if.sv
// Request/grant and CPU HOLD/HLDA handshake between the arbiter and the system.
interface hold_arbiter_if
    import hold_arb_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]            REQ;
    logic                       HLDA;
    logic                       HOLD;
    logic [NREQ-1:0]            GNT;
    logic [idx_width(NREQ)-1:0] OWNER;
    logic                       BUSY;

    modport master (
        input  REQ,
        input  HLDA,
        output HOLD,
        output GNT,
        output OWNER,
        output BUSY
    );

    modport slave (
        output REQ,
        output HLDA,
        input  HOLD,
        input  GNT,
        input  OWNER,
        input  BUSY
    );
endinterface

// File: rtl/hold_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import hold_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    logic [NREQ-1:0] rot;
    logic [IW-1:0]   off;
    logic [IW:0]     sum;

    always_comb begin
        rot   = NREQ'({req, req} >> ptr);
        off   = '0;
        valid = 1'b0;
        // Descending scan so the smallest offset from ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off   = IW'(k);
                valid = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW + 1)'(NREQ)) begin
            sum = sum - (IW + 1)'(NREQ);
        end
        winner = sum[IW-1:0];
    end

endmodule

// File: rtl/hold_arbiter.sv
// Shares the 8088 bus between the CPU and NREQ external masters via HOLD/HLDA,
// with round-robin selection, bounded tenure and a guaranteed CPU gap.
module hold_arbiter
    import hold_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int MAX_TENURE = 16,
    parameter int GAP        = 2
) (
    input logic          CLK,
    input logic          RESET,
    hold_arbiter_if.master bus
);

    localparam int IW  = idx_width(NREQ);
    localparam int TCW = $clog2(MAX_TENURE + 1);
    localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    arb_state_e      state_q, state_d;
    logic            hold_q, hold_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            busy_q, busy_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [TCW-1:0]  tcnt_q, tcnt_d;
    logic [GCW-1:0]  gcnt_q, gcnt_d;

    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic [IW:0]     ptr_inc;
    logic [IW-1:0]   ptr_next;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (bus.REQ),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign ptr_inc  = {1'b0, pick_idx} + (IW + 1)'(1);
    assign ptr_next = (ptr_inc == (IW + 1)'(NREQ)) ? '0 : ptr_inc[IW-1:0];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.REQ) begin
                    state_d = WAIT_ACK;
                    hold_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (bus.HLDA) begin
                    if (pick_valid) begin
                        state_d = GRANT;
                        gnt_d   = NREQ'(1) << pick_idx;
                        owner_d = pick_idx;
                        ptr_d   = ptr_next;
                        tcnt_d  = '0;
                    end else begin
                        state_d = RELEASE;
                        hold_d  = 1'b0;
                    end
                end
            end
            GRANT: begin
                // Lost HLDA, withdrawn request and expired tenure all release alike.
                if (!bus.HLDA || !bus.REQ[owner_q] || tcnt_q == TCW'(MAX_TENURE - 1)) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    hold_d  = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end
            RELEASE: begin
                if (!bus.HLDA) begin
                    if (GAP == 0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = CPU_GAP;
                        gcnt_d  = '0;
                    end
                end
            end
            CPU_GAP: begin
                if (gcnt_q == GCW'(GAP - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gcnt_d = gcnt_q + GCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 1'b0;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            hold_q  <= 1'b0;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign bus.HOLD  = hold_q;
    assign bus.GNT   = gnt_q;
    assign bus.OWNER = owner_q;
    assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_hold_arbiter.sv
// Self-checking bench for hold_arbiter: fixed vector table, directed sequences, random vs model.
module tb_hold_arbiter;
    import hold_arb_pkg::*;

    localparam int NREQ       = 4;
    localparam int MAX_TENURE = 16;
    localparam int GAP        = 2;
    localparam int OW         = idx_width(NREQ);

    logic CLK = 1'b0;
    logic RESET;

    hold_arbiter_if #(.NREQ(NREQ)) bus ();

    hold_arbiter #(.NREQ(NREQ), .MAX_TENURE(MAX_TENURE), .GAP(GAP)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec     = 0;
    int n_miscmp  = 0;

    typedef struct {
        bit              rst;
        logic [NREQ-1:0] req;
        bit              hlda;
        bit              hold;
        logic [NREQ-1:0] gnt;
        logic [OW-1:0]   owner;
        bit              busy;
    } vec_t;

    vec_t tbl [29];

    // Reference model: who holds the bus, how long, and what remains of the CPU gap.
    int m_gidx;
    int m_used;
    int m_gap_left;
    int m_ptr;
    int m_owner;
    bit m_hold;
    bit m_busy;
    bit m_rel;

    task automatic model_step(input bit rst, input logic [NREQ-1:0] req, input bit hlda);
        bit found;
        int idx;
        if (rst) begin
            m_gidx = -1; m_used = 0; m_gap_left = 0; m_ptr = 0; m_owner = 0;
            m_hold = 0; m_busy = 0; m_rel = 0;
        end else if (m_gidx >= 0) begin
            m_used++;
            if (!hlda || !req[m_gidx] || m_used == MAX_TENURE) begin
                m_gidx = -1; m_hold = 0; m_rel = 1;
            end
        end else if (m_rel) begin
            if (!hlda) begin
                m_rel = 0;
                if (GAP == 0) m_busy = 0;
                else m_gap_left = GAP;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
            if (m_gap_left == 0) m_busy = 0;
        end else if (m_hold) begin
            if (hlda) begin
                found = 0;
                for (int j = 0; j < NREQ; j++) begin
                    idx = (m_ptr + j) % NREQ;
                    if (!found && req[idx]) begin
                        found = 1; m_gidx = idx; m_owner = idx; m_used = 0;
                        m_ptr = (idx + 1) % NREQ;
                    end
                end
                if (!found) begin
                    m_hold = 0; m_rel = 1;
                end
            end
        end else if (req != 0) begin
            m_hold = 1; m_busy = 1;
        end
    endtask

    task automatic apply(input bit rst, input logic [NREQ-1:0] req, input bit hlda);
        RESET    = rst;
        bus.REQ  = req;
        bus.HLDA = hlda;
        @(posedge CLK);
        model_step(rst, req, hlda);
        #1;
    endtask

    task automatic check_model(input string nm);
        logic [NREQ-1:0] eg;
        eg = '0;
        if (m_gidx >= 0) eg[m_gidx] = 1'b1;
        n_vec++;
        if (bus.HOLD !== m_hold || bus.GNT !== eg || bus.OWNER !== OW'(m_owner) || bus.BUSY !== m_busy) begin
            n_miscmp++;
            $display("FAIL %s t=%0t got hold=%b gnt=%b owner=%0d busy=%b, want hold=%b gnt=%b owner=%0d busy=%b",
                     nm, $time, bus.HOLD, bus.GNT, bus.OWNER, bus.BUSY, m_hold, eg, m_owner, m_busy);
        end
    endtask

    task automatic check_val(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_miscmp++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, got, want);
        end
    endtask

    task automatic check_row(input int i);
        n_vec++;
        if (bus.HOLD !== tbl[i].hold || bus.GNT !== tbl[i].gnt || bus.OWNER !== tbl[i].owner || bus.BUSY !== tbl[i].busy) begin
            n_miscmp++;
            $display("FAIL table_row%0d got hold=%b gnt=%b owner=%0d busy=%b, want hold=%b gnt=%b owner=%0d busy=%b",
                     i, bus.HOLD, bus.GNT, bus.OWNER, bus.BUSY, tbl[i].hold, tbl[i].gnt, tbl[i].owner, tbl[i].busy);
        end
    endtask

    initial begin
        logic [1:0]      hpipe;
        logic [NREQ-1:0] prev_gnt;
        logic [NREQ-1:0] rreq;
        bit              rhlda;
        bit              rrst;
        int              run_len;
        int              n_runs;
        int              low_run;
        bit              seen_hold;
        int              gcyc;
        bit              granted;
        int              order [$];

        //              rst  req      hlda hold gnt      own  busy
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1};
        tbl[2]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1};
        tbl[3]  = '{1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[4]  = '{1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1};
        tbl[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1};
        tbl[7]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1};
        tbl[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1};
        tbl[9]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0};
        tbl[11] = '{1'b0, 4'b1000, 1'b1, 1'b1, 4'b0000, 2'd1, 1'b1};
        tbl[12] = '{1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1};
        tbl[13] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1};
        tbl[14] = '{1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1};
        tbl[15] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1};
        tbl[16] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0};
        tbl[17] = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b1};
        tbl[18] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b1};
        tbl[19] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b1};
        tbl[20] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1};
        tbl[21] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1};
        tbl[22] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0};
        tbl[23] = '{1'b0, 4'b1100, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b1};
        tbl[24] = '{1'b0, 4'b1100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[25] = '{1'b1, 4'b1100, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[26] = '{1'b0, 4'b1100, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b1};
        tbl[27] = '{1'b0, 4'b1100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[28] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};

        RESET = 1'b1; bus.REQ = '0; bus.HLDA = 1'b0;
        model_step(1'b1, '0, 1'b0);
        @(negedge CLK);

        for (int i = 0; i < 29; i++) begin
            apply(tbl[i].rst, tbl[i].req, tbl[i].hlda);
            check_row(i);
        end

        // Tenure preemption: one permanent requester, CPU acks two cycles after HOLD.
        apply(1'b1, '0, 1'b0);
        check_model("tenure_reset");
        hpipe = 2'b00; run_len = 0; n_runs = 0; low_run = 0; seen_hold = 0; prev_gnt = '0;
        for (int c = 0; c < 90; c++) begin
            apply(1'b0, 4'b0001, hpipe[1]);
            hpipe = {hpipe[0], bus.HOLD};
            check_model("tenure_seq");
            if (bus.GNT != 0 && prev_gnt == 0) check_val("regrant_owner", int'(bus.OWNER), 0);
            if (bus.GNT[0]) run_len++;
            else if (run_len != 0) begin
                check_val("tenure_len", run_len, MAX_TENURE);
                n_runs++; run_len = 0;
            end
            if (!bus.HOLD) low_run++;
            else begin
                if (seen_hold && low_run != 0) check_val("cpu_gap_ok", int'(low_run >= GAP + 2), 1);
                seen_hold = 1; low_run = 0;
            end
            prev_gnt = bus.GNT;
        end
        check_val("tenure_runs_ge2", int'(n_runs >= 2), 1);

        // Round-robin fairness with all four requesting.
        apply(1'b1, '0, 1'b0);
        hpipe = 2'b00; run_len = 0; prev_gnt = '0;
        order.delete();
        for (int c = 0; c < 170; c++) begin
            apply(1'b0, 4'b1111, hpipe[1]);
            hpipe = {hpipe[0], bus.HOLD};
            check_model("rr_seq");
            if (bus.GNT != 0) begin
                if (prev_gnt == 0) order.push_back(int'(bus.OWNER));
                run_len++;
            end else if (run_len != 0) begin
                check_val("rr_len", run_len, MAX_TENURE);
                run_len = 0;
            end
            prev_gnt = bus.GNT;
        end
        check_val("rr_count_ge5", int'(order.size() >= 5), 1);
        for (int k = 0; k < 5 && k < order.size(); k++) check_val("rr_order", order[k], k % NREQ);

        // Reset during the fifth GNT cycle of requester 2, then 1100 must go to 2.
        apply(1'b1, '0, 1'b0);
        hpipe = 2'b00; gcyc = 0;
        for (int c = 0; c < 20 && gcyc < 5; c++) begin
            apply(1'b0, 4'b0100, hpipe[1]);
            hpipe = {hpipe[0], bus.HOLD};
            check_model("midgrant_seq");
            if (bus.GNT[2]) gcyc++;
        end
        check_val("midgrant_reached5", gcyc, 5);
        apply(1'b1, 4'b0100, 1'b1);
        check_val("rst_outputs_zero", int'({bus.HOLD, bus.GNT, bus.OWNER, bus.BUSY}), 0);
        hpipe = 2'b00; granted = 0;
        for (int c = 0; c < 12 && !granted; c++) begin
            apply(1'b0, 4'b1100, hpipe[1]);
            hpipe = {hpipe[0], bus.HOLD};
            check_model("post_rst_seq");
            if (bus.GNT != 0) begin
                granted = 1;
                check_val("post_rst_winner", int'(bus.OWNER), 2);
            end
        end
        check_val("post_rst_granted", int'(granted), 1);

        // Random traffic: sticky requests, a loosely-behaved CPU, occasional glitches and resets.
        apply(1'b1, '0, 1'b0);
        rreq = '0; rhlda = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NREQ; b++) if ($urandom_range(9) == 0) rreq[b] = ~rreq[b];
            if ($urandom_range(63) == 0) rhlda = ~rhlda;
            else if (bus.HOLD) begin
                if ($urandom_range(2) == 0) rhlda = 1'b1;
            end else if ($urandom_range(1) == 0) rhlda = 1'b0;
            rrst = ($urandom_range(299) == 0);
            apply(rrst, rreq, rhlda);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
